// File: rtl/sramctrl_pkg.sv
// Shared definitions for the parametrised AHB-to-SRAM control interface:
// FSM state codes, HSIZE codes, and the byte-enable / parity helpers.
package sramctrl_pkg;

  // FSM state encoding (plain constants so older flows can consume them)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WR      = 2'd1;
  localparam state_t ST_RD_WAIT = 2'd2;
  localparam state_t ST_ERR     = 2'd3;

  // AHB HSIZE codes used by the request interface
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

  // 2^size contiguous lanes starting at lane 'offset'; lanes >= nb stay 0.
  // The result is always 8 bits wide, callers slice off their NB lanes.
  function automatic logic [7:0] be_gen(input logic [2:0] size,
                                        input logic [2:0] offset,
                                        input int         nb);
    logic [7:0] be;
    be = '0;
    for (int i = 0; i < 8; i++) begin
      if ((i < nb) && (i >= int'(offset)) && (i < int'(offset) + (1 << size)))
        be[i] = 1'b1;
    end
    return be;
  endfunction

  // Even parity bit: total number of ones in {byte, parity} is even
  function automatic logic even_par8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sramctrl_rd_pipe.sv
// Read-latency tracker: a valid token enters with the read strobe and
// emerges RD_LATENCY cycles later, which is exactly the cycle in which the
// SRAM macro presents valid read data. Legal RD_LATENCY range is 1..4.
module sramctrl_rd_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tok_in,
  output logic cap_en
);

  logic [RD_LATENCY-1:0] stage_q;
  logic [RD_LATENCY-1:0] stage_d;

  // Shift the token one stage per cycle
  always_comb begin
    stage_d    = '0;
    stage_d[0] = tok_in;
    for (int i = 1; i < RD_LATENCY; i++) stage_d[i] = stage_q[i-1];
  end

  // Stage registers; reset drops any token in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign cap_en = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/sramctrl_if_gen.sv
// Parametrised single-port AHB-to-SRAM control interface. Takes level-held
// requests from the AHB slave FSM, drives registered strobes to one
// byte-lane SRAM macro, and flags illegal size/alignment with err.
// Optional byte parity on the SRAM data path: define SRAMCTRL_BYTE_PARITY_EN.
//
// Handshake: a request is taken only in IDLE, outside the ack cycle, while
// req=1 and sram_busy=0; address, size, direction and write data are sampled
// in that cycle. ack pulses for one cycle on completion (with err for an
// illegal access or a read parity error); req is ignored until the cycle
// after ack, when the master must have dropped it or present a new request.
module sramctrl_if_gen
  import sramctrl_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 20,
  parameter int RD_LATENCY = 1
) (
  input  logic                                      HCLK,
  input  logic                                      HRESET,
  input  logic                                      req,
  input  logic                                      write,
  input  logic [2:0]                                size,
  input  logic [AWIDTH-1:0]                         addr,
  input  logic [DWIDTH-1:0]                         wdata,
  output logic                                      ack,
  output logic                                      err,
  output logic [DWIDTH-1:0]                         rdata,
  output logic                                      busy,
  output logic [AWIDTH-$clog2(DWIDTH/8)-1:0]        sram_addr,
  output logic [DWIDTH/8-1:0]                       sram_be,
  output logic                                      sram_wen,
  output logic                                      sram_ren,
  output logic [DWIDTH-1:0]                         sram_wdata,
  input  logic [DWIDTH-1:0]                         sram_rdata,
  input  logic                                      sram_busy,
`ifdef SRAMCTRL_BYTE_PARITY_EN
  output logic [DWIDTH/8-1:0]                       sram_wpar,
  input  logic [DWIDTH/8-1:0]                       sram_rpar,
`endif
  output logic [1:0]                                dbg_state
);

  localparam int NB  = DWIDTH / 8;
  localparam int OFS = $clog2(NB);

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [AWIDTH-OFS-1:0] sram_addr_q, sram_addr_d;
  logic [NB-1:0]       sram_be_q, sram_be_d;
  logic                sram_wen_q, sram_wen_d;
  logic                sram_ren_q, sram_ren_d;
  logic [DWIDTH-1:0]   sram_wdata_q, sram_wdata_d;

  logic                accept, illegal, accept_wr, accept_rd;
  logic [AWIDTH-1:0]   align_mask;
  logic [7:0]          be_full;
  logic                cap_en;
  logic                par_err;

  // Request decode: acceptance window, legality and lane mask
  always_comb begin
    accept     = (state_q == ST_IDLE) && !ack_q && req && !sram_busy;
    align_mask = AWIDTH'((32'd1 << size) - 32'd1);
    illegal    = (int'(size) > OFS) || ((addr & align_mask) != '0);
    be_full    = be_gen(size, 3'(addr[OFS-1:0]), NB);
    accept_wr  = accept && !illegal && write;
    accept_rd  = accept && !illegal && !write;
  end

  sramctrl_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
    .clk    (HCLK),
    .rst    (HRESET),
    .tok_in (sram_ren_q),
    .cap_en (cap_en)
  );

`ifdef SRAMCTRL_BYTE_PARITY_EN
  logic [NB-1:0] rd_be_q, rd_be_d;
  logic [NB-1:0] sram_wpar_q, sram_wpar_d;

  // Remember requested read lanes and form write parity alongside wdata
  always_comb begin
    rd_be_d     = accept_rd ? be_full[NB-1:0] : rd_be_q;
    sram_wpar_d = sram_wpar_q;
    if (accept_wr)
      for (int i = 0; i < NB; i++) sram_wpar_d[i] = even_par8(wdata[8*i +: 8]);
  end

  // Parity check of the captured word, limited to requested lanes
  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < NB; i++)
      if (rd_be_q[i] && (even_par8(sram_rdata[8*i +: 8]) != sram_rpar[i]))
        par_err = 1'b1;
  end

  // Parity-side registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_be_q     <= '0;
      sram_wpar_q <= '0;
    end else begin
      rd_be_q     <= rd_be_d;
      sram_wpar_q <= sram_wpar_d;
    end
  end

  assign sram_wpar = sram_wpar_q;
`else
  assign par_err = 1'b0;
`endif

  // Access FSM: one-cycle strobe, then ack; reads wait for the token
  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_be_d    = '0;
    sram_wen_d   = 1'b0;
    sram_ren_d   = 1'b0;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (write) begin
            state_d      = ST_WR;
            sram_addr_d  = addr[AWIDTH-1:OFS];
            sram_wen_d   = 1'b1;
            sram_be_d    = be_full[NB-1:0];
            sram_wdata_d = wdata;
          end else begin
            state_d     = ST_RD_WAIT;
            sram_addr_d = addr[AWIDTH-1:OFS];
            sram_ren_d  = 1'b1;
          end
        end
      end
      ST_WR: begin
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cap_en) begin
          rdata_d = sram_rdata;
          ack_d   = 1'b1;
          err_d   = par_err;
          state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state and all outputs; reset aborts any access in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_be_q    <= '0;
      sram_wen_q   <= 1'b0;
      sram_ren_q   <= 1'b0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_be_q    <= sram_be_d;
      sram_wen_q   <= sram_wen_d;
      sram_ren_q   <= sram_ren_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_be    = sram_be_q;
  assign sram_wen   = sram_wen_q;
  assign sram_ren   = sram_ren_q;
  assign sram_wdata = sram_wdata_q;
  assign busy       = (state_q != ST_IDLE) || sram_busy;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sramctrl_if_gen.sv
// Bench for sramctrl_if_gen: two instances (32-bit/latency 1 and
// 64-bit/latency 3) share stimulus lines and each has a behavioural SRAM.
// Expected values come from a byte-level reference memory and the access
// rules (lane arithmetic, alignment, fixed completion latency).
module tb_sramctrl_if_gen;
  import sramctrl_pkg::*;

  localparam int AW = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          req0, req1, write, sram_busy;
  logic [2:0]    size;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic [3:0]    flip0;

  // ---------------- DUT0: DWIDTH=32, RD_LATENCY=1 ----------------
  logic          ack0, err0, busy0, wen0, ren0;
  logic [31:0]   rdata0, swd0, srd0;
  logic [AW-3:0] saddr0;
  logic [3:0]    be0, wpar0, rpar0;
  logic [1:0]    st0;

  // ---------------- DUT1: DWIDTH=64, RD_LATENCY=3 ----------------
  logic          ack1, err1, busy1, wen1, ren1;
  logic [63:0]   rdata1, swd1, srd1;
  logic [AW-4:0] saddr1;
  logic [7:0]    be1, wpar1, rpar1;
  logic [1:0]    st1;

  sramctrl_if_gen #(.DWIDTH(32), .AWIDTH(AW), .RD_LATENCY(1)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .req(req0), .write(write), .size(size),
    .addr(addr), .wdata(wdata[31:0]), .ack(ack0), .err(err0),
    .rdata(rdata0), .busy(busy0), .sram_addr(saddr0), .sram_be(be0),
    .sram_wen(wen0), .sram_ren(ren0), .sram_wdata(swd0),
    .sram_rdata(srd0), .sram_busy(sram_busy),
`ifdef SRAMCTRL_BYTE_PARITY_EN
    .sram_wpar(wpar0), .sram_rpar(rpar0),
`endif
    .dbg_state(st0)
  );

  sramctrl_if_gen #(.DWIDTH(64), .AWIDTH(AW), .RD_LATENCY(3)) u_dut1 (
    .HCLK(clk), .HRESET(rst), .req(req1), .write(write), .size(size),
    .addr(addr), .wdata(wdata), .ack(ack1), .err(err1),
    .rdata(rdata1), .busy(busy1), .sram_addr(saddr1), .sram_be(be1),
    .sram_wen(wen1), .sram_ren(ren1), .sram_wdata(swd1),
    .sram_rdata(srd1), .sram_busy(sram_busy),
`ifdef SRAMCTRL_BYTE_PARITY_EN
    .sram_wpar(wpar1), .sram_rpar(rpar1),
`endif
    .dbg_state(st1)
  );

`ifndef SRAMCTRL_BYTE_PARITY_EN
  assign wpar0 = '0;
  assign wpar1 = '0;
`endif

  // ---------------- behavioural SRAM macros ----------------
  logic [31:0] mem0 [0:63];
  logic [63:0] mem1 [0:31];
  logic [31:0] pipe0;
  logic [63:0] pipe1 [0:2];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Read data appears exactly RD_LATENCY cycles after the strobe; junk otherwise
  always @(posedge clk) begin
    if (wen0) mem0[saddr0[5:0]] <= 32'(merge({32'b0, mem0[saddr0[5:0]]}, {32'b0, swd0}, {4'b0, be0}));
    if (wen1) mem1[saddr1[4:0]] <= merge(mem1[saddr1[4:0]], swd1, be1);
    pipe0    <= ren0 ? mem0[saddr0[5:0]] : $urandom();
    pipe1[0] <= ren1 ? mem1[saddr1[4:0]] : {$urandom(), $urandom()};
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign srd0 = pipe0;
  assign srd1 = pipe1[2];

  always_comb begin
    for (int i = 0; i < 4; i++) rpar0[i] = (^srd0[8*i +: 8]) ^ flip0[i];
    for (int i = 0; i < 8; i++) rpar1[i] = ^srd1[8*i +: 8];
  end

  // ---------------- observation mux ----------------
  int          which;
  logic        o_ack, o_err, o_busy, o_wen, o_ren;
  logic [7:0]  o_be, o_wpar;
  logic [63:0] o_saddr, o_swd, o_rdata;
  always_comb begin
    o_ack   = (which == 1) ? ack1  : ack0;
    o_err   = (which == 1) ? err1  : err0;
    o_busy  = (which == 1) ? busy1 : busy0;
    o_wen   = (which == 1) ? wen1  : wen0;
    o_ren   = (which == 1) ? ren1  : ren0;
    o_be    = (which == 1) ? be1   : {4'b0, be0};
    o_wpar  = (which == 1) ? wpar1 : {4'b0, wpar0};
    o_saddr = (which == 1) ? 64'(saddr1) : 64'(saddr0);
    o_swd   = (which == 1) ? swd1   : {32'b0, swd0};
    o_rdata = (which == 1) ? rdata1 : {32'b0, rdata0};
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  ref_mem [0:1][0:255];
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int w, input string tag);
    which = w;
    #0;
    chk({tag, " ack"},   64'(o_ack),  64'd0);
    chk({tag, " err"},   64'(o_err),  64'd0);
    chk({tag, " wen"},   64'(o_wen),  64'd0);
    chk({tag, " ren"},   64'(o_ren),  64'd0);
    chk({tag, " be"},    64'(o_be),   64'd0);
    chk({tag, " saddr"}, o_saddr,     64'd0);
    chk({tag, " swd"},   o_swd,       64'd0);
    chk({tag, " rdata"}, o_rdata,     64'd0);
    chk({tag, " busy"},  64'(o_busy), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      next_cycle();
      chk("gap no ack", 64'(o_ack), 64'd0);
    end
  endtask

  // Called at the start of an idle cycle N; returns inside the ack cycle with req still held
  task automatic access(input int w, input logic wr, input logic [2:0] sz,
                        input logic [AW-1:0] a, input logic [63:0] wd,
                        input logic [3:0] flip, input bit busy_after);
    int nb, rl, lanes, ai, base;
    bit bad;
    logic [7:0]  ebe, epar;
    logic [63:0] ewd, erd;
    logic        eerr;
    nb    = (w == 1) ? 8 : 4;
    rl    = (w == 1) ? 3 : 1;
    ai    = int'(a);
    lanes = (sz > 3'd3) ? 16 : (1 << sz);
    bad   = (lanes > nb) || ((ai % lanes) != 0);
    base  = (ai / nb) * nb;
    ebe   = bad ? 8'h00 : 8'(((1 << lanes) - 1) << (ai % nb));
    ewd   = '0;
    epar  = '0;
    for (int b = 0; b < nb; b++) begin
      ewd[8*b +: 8] = wd[8*b +: 8];
      epar[b]       = ^wd[8*b +: 8];
    end
    which = w;
    write = wr; size = sz; addr = a; wdata = wd;
    flip0 = (w == 0) ? flip : 4'h0;
    if (w == 1) req1 = 1'b1; else req0 = 1'b1;
    if (!bad && wr)
      for (int b = 0; b < nb; b++) if (ebe[b]) ref_mem[w][(base + b) % 256] = wd[8*b +: 8];
    if (!bad && !wr) begin
      erd = '0;
      for (int b = 0; b < nb; b++) erd[8*b +: 8] = ref_mem[w][(base + b) % 256];
      exp_q.push_back(erd);
    end
    @(posedge clk); #1;                                   // cycle N+1
    if (bad) begin
      chk("illegal ack", 64'(o_ack), 64'd1);
      chk("illegal err", 64'(o_err), 64'd1);
      chk("illegal wen", 64'(o_wen), 64'd0);
      chk("illegal ren", 64'(o_ren), 64'd0);
    end else if (wr) begin
      chk("wr wen",   64'(o_wen),  64'd1);
      chk("wr ren",   64'(o_ren),  64'd0);
      chk("wr be",    64'(o_be),   64'(ebe));
      chk("wr saddr", o_saddr,     64'(ai / nb));
      chk("wr wdata", o_swd,       ewd);
      chk("wr busy",  64'(o_busy), 64'd1);
      chk("wr early ack", 64'(o_ack), 64'd0);
`ifdef SRAMCTRL_BYTE_PARITY_EN
      chk("wr wpar",  64'(o_wpar), 64'(epar));
`endif
      if (busy_after) sram_busy = 1'b1;
      @(posedge clk); #1;                                 // cycle N+2
      chk("wr ack", 64'(o_ack), 64'd1);
      chk("wr err", 64'(o_err), 64'd0);
      chk("wr wen single", 64'(o_wen), 64'd0);
    end else begin
      chk("rd ren",   64'(o_ren),  64'd1);
      chk("rd wen",   64'(o_wen),  64'd0);
      chk("rd be",    64'(o_be),   64'd0);
      chk("rd saddr", o_saddr,     64'(ai / nb));
      chk("rd busy",  64'(o_busy), 64'd1);
      if (busy_after) sram_busy = 1'b1;
      repeat (rl) begin                                   // N+2 .. N+1+RD_LATENCY
        @(posedge clk); #1;
        chk("rd wait ack", 64'(o_ack), 64'd0);
        chk("rd ren single", 64'(o_ren), 64'd0);
      end
      @(posedge clk); #1;                                 // N+2+RD_LATENCY
      eerr = 1'b0;
`ifdef SRAMCTRL_BYTE_PARITY_EN
      eerr = |(flip0 & ebe[3:0]);
`endif
      chk("rd ack",   64'(o_ack), 64'd1);
      chk("rd err",   64'(o_err), 64'(eerr));
      chk("rd rdata", o_rdata,    exp_q.pop_front());
    end
    sram_busy = 1'b0;
    flip0     = 4'h0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; write = 0; size = SZ_BYTE; addr = '0;
    wdata = '0; sram_busy = 0; flip0 = '0; which = 0;
    for (int i = 0; i < 64; i++) mem0[i] = '0;
    for (int i = 0; i < 32; i++) mem1[i] = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[0][i] = '0; ref_mem[1][i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs(0, "reset d0");
    chk_reset_outputs(1, "reset d1");
    rst = 1'b0;
    next_cycle();

    // word write then read back, 32-bit / latency 1
    access(0, 1, SZ_WORD, 20'h10, 64'hA5A5_1234, 4'h0, 0);
    next_cycle();
    access(0, 0, SZ_WORD, 20'h10, 64'h0, 4'h0, 0);
    next_cycle();
    // byte lane 3 and upper halfword
    access(0, 1, SZ_BYTE, 20'h13, 64'h7700_0000, 4'h0, 0);
    next_cycle();
    access(0, 1, SZ_HALF, 20'h02, 64'hBEEF_0000, 4'h0, 0);
    next_cycle();
    access(0, 0, SZ_BYTE, 20'h13, 64'h0, 4'h0, 0);
    next_cycle();
    // illegal: misaligned word, dword on a 32-bit port, misaligned read
    access(0, 1, SZ_WORD, 20'h06, 64'h1111_2222, 4'h0, 0);
    next_cycle();
    access(0, 1, SZ_DWORD, 20'h00, 64'h3333_4444, 4'h0, 0);
    next_cycle();
    access(0, 0, SZ_HALF, 20'h05, 64'h0, 4'h0, 0);
    next_cycle();
    access(0, 0, SZ_WORD, 20'h00, 64'h0, 4'h0, 0);
    next_cycle();

    // 64-bit / latency 3 dword write and read
    access(1, 1, SZ_DWORD, 20'h18, 64'hDEAD_BEEF_0123_4567, 4'h0, 0);
    next_cycle();
    access(1, 0, SZ_DWORD, 20'h18, 64'h0, 4'h0, 0);
    next_cycle();
    access(1, 1, SZ_WORD, 20'h1C, 64'hCAFE_F00D_0000_0000, 4'h0, 0);
    next_cycle();
    access(1, 0, SZ_BYTE, 20'h1D, 64'h0, 4'h0, 0);
    next_cycle();

    // sram_busy blocks acceptance while req is held
    which = 0; sram_busy = 1'b1;
    req0 = 1'b1; write = 1'b1; size = SZ_WORD; addr = 20'h20; wdata = 64'h5A5A_0F0F;
    repeat (5) begin
      @(posedge clk); #1;
      chk("busy hold wen", 64'(o_wen),  64'd0);
      chk("busy hold ack", 64'(o_ack),  64'd0);
      chk("busy hold busy", 64'(o_busy), 64'd1);
    end
    sram_busy = 1'b0;
    access(0, 1, SZ_WORD, 20'h20, 64'h5A5A_0F0F, 4'h0, 0);
    next_cycle();
    // sram_busy rising after acceptance does not stall
    access(1, 0, SZ_DWORD, 20'h18, 64'h0, 4'h0, 1);
    next_cycle();
    access(0, 0, SZ_WORD, 20'h20, 64'h0, 4'h0, 1);
    next_cycle();

`ifdef SRAMCTRL_BYTE_PARITY_EN
    // parity: flipped lane 1 matters for a word read, not for a lane-0 byte read
    access(0, 1, SZ_WORD, 20'h40, 64'h1357_9BDF, 4'h0, 0);
    next_cycle();
    access(0, 0, SZ_WORD, 20'h40, 64'h0, 4'h2, 0);
    next_cycle();
    access(0, 0, SZ_BYTE, 20'h40, 64'h0, 4'h2, 0);
    next_cycle();
`endif

    // randomized mix over both instances
    for (int n = 0; n < 80; n++) begin
      int          w;
      logic [2:0]  sz;
      logic [AW-1:0] a;
      w  = int'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a  = AW'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd3) a = a & ~(AW'((1 << sz) - 1));
      access(w, 1'($urandom_range(0, 1)), sz, a, {$urandom(), $urandom()},
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0));
      next_cycle();
      if ($urandom_range(0, 2) == 0) gap(int'($urandom_range(1, 3)));
    end

    // reset in the middle of a latency-3 read: abort, no ack afterwards
    which = 1; req1 = 1'b1; write = 1'b0; size = SZ_DWORD; addr = 20'h18;
    @(posedge clk); #1;                                   // N+1
    @(posedge clk); #1;                                   // N+2
    rst = 1'b1;
    req1 = 1'b0;
    #1;
    chk_reset_outputs(1, "abort d1");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort no ack", 64'(o_ack), 64'd0);
    end
    access(1, 0, SZ_DWORD, 20'h18, 64'h0, 4'h0, 0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sramctrl_if_gen.md
Name: sramctrl_if_gen

Overview:
- Parametrised successor of the single-port AHB-to-SRAM control interface.
- Accepts level-held requests from the AHB slave front end and drives one external byte-lane SRAM macro.
- Generalises data width and SRAM read latency, registers all SRAM strobes, and reports errors for illegal size or alignment.
- Sits between the AHB slave FSM and the LSRAM/uSRAM macro wrapper.

Parameters:
- DWIDTH, 32, data width; 32 or 64. NB = DWIDTH/8 byte lanes; OFS = log2(NB).
- AWIDTH, 20, byte-address width of the request.
- RD_LATENCY, 1, cycles from sram_ren to valid sram_rdata; legal range 1..4.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous active-high reset
- req  in  1  access request; held until ack
- write  in  1  1=write, 0=read; valid with req
- size  in  3  HSIZE encoding (0=byte, 1=half, 2=word, 3=dword)
- addr  in  AWIDTH  byte address
- wdata  in  DWIDTH  write data, lane-aligned
- ack  out  1  one-cycle completion pulse
- err  out  1  pulses with ack on an illegal access
- rdata  out  DWIDTH  read data; held until the next read completes
- busy  out  1  state!=IDLE or sram_busy
- sram_addr  out  AWIDTH-OFS  word address
- sram_be  out  NB  byte write enables
- sram_wen  out  1  write strobe
- sram_ren  out  1  read strobe
- sram_wdata  out  DWIDTH  write data
- sram_rdata  in  DWIDTH  macro read data
- sram_busy  in  1  macro busy (e.g. initialisation); blocks acceptance

Behaviour:
- Reset: ack, err, sram_wen, sram_ren, sram_be, sram_addr, sram_wdata, rdata and busy are 0; state IDLE. Reset during an access aborts it and no ack is issued.
- States: IDLE, WR, RD_WAIT, ERR.
- Acceptance: only in IDLE, when req=1 and sram_busy=0. Call this cycle N. In cycle N, addr, size, write and wdata are registered.
- Legality: the access is illegal if size>OFS, or if addr is not a multiple of 2^size. An illegal access goes to ERR with no SRAM strobe. At N+1, ack=err=1; then the FSM returns to IDLE.
- Write: go to WR. At N+1, sram_wen=1 for exactly 1 cycle with sram_be, sram_addr=addr[AWIDTH-1:OFS] and sram_wdata. At N+2, ack=1; FSM returns to IDLE.
- Read: go to RD_WAIT. At N+1, sram_ren=1 for 1 cycle and sram_be=0. A valid token travels a RD_LATENCY-deep shift register. When the token emerges (cycle N+1+RD_LATENCY), rdata<=sram_rdata. At N+2+RD_LATENCY, ack=1.
- Byte enables: 2^size contiguous lanes starting at lane addr[OFS-1:0]. For example, DWIDTH=32, size=1, addr[1:0]=2 gives be=4'b1100.
- Handshake:
  - req is ignored in the ack cycle and in every non-IDLE state.
  - The next acceptance is possible in the cycle after ack.
  - A master must drop req or present a new request after ack.
  - Throughput: one write per 3 cycles.
- sram_busy rising after acceptance does not stall the in-flight access; it only blocks the next acceptance.
- Strobes are never asserted simultaneously. rdata is never updated by writes.

Optional Feature:
- Macro: SRAMCTRL_BYTE_PARITY_EN.
- With the macro defined:
  - Adds ports sram_wpar out NB and sram_rpar in NB.
  - sram_wpar carries even parity per byte, registered with sram_wdata.
  - On read capture, any mismatch on a lane the read requested makes err=1 with the ack; rdata is still updated.
- Without the macro: the ports are absent and err is raised only for illegal accesses.

Decomposition:
- Package sramctrl_pkg holds:
  - state enum {IDLE, WR, RD_WAIT, ERR};
  - HSIZE constants SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - function be_gen(size, offset, NB);
  - function even_par8.
- Sub-module sramctrl_rd_pipe: parametrised RD_LATENCY valid shift register with a capture-enable output; reset clears all stages.

Test Plan:
- DWIDTH=32, RD_LATENCY=1: write addr=0x10, size=2, wdata=0xA5A5_1234 -> sram_wen at N+1, be=4'hF, sram_addr=0x4, ack at N+2. Then read 0x10 (model returns 0xA5A5_1234) -> ack at N+3, rdata=0xA5A5_1234.
- Byte write addr=0x13, size=0, wdata=0x7700_0000 -> be=4'b1000. Halfword addr=0x2 -> be=4'b1100.
- Illegal accesses: size=2 at addr=0x6 -> ack=err=1 at N+1, no sram_wen/ren. size=3 with DWIDTH=32 -> same.
- RD_LATENCY=3, DWIDTH=64: read addr=0x18, size=3 -> sram_ren at N+1, sram_addr=0x3, ack at N+5, rdata matches the model.
- sram_busy=1 with req held for 5 cycles -> no acceptance, busy=1. Drop sram_busy -> accept next cycle. Assert HRESET at N+2 of a RD_LATENCY=3 read -> outputs 0, no ack after reset release.
- SRAMCTRL_BYTE_PARITY_EN: flip sram_rpar[1] on a word read -> ack with err=1. A byte read of lane 0 with the same flip -> err=0.
